// File: rtl/instruction_fetch.sv
// Fetch stage feeding a synchronous 1-cycle instruction ROM: PC register, stall and redirect.
// Optional performance counters are built only when IFETCH_PERF_EN is defined.
module instruction_fetch #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]         NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]           rom_data_i,
    output logic [31:0]           instr_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic                  valid_o,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           stall_cnt_o
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   req_pc_p0;
    logic [PC_WIDTH-1:0]   nxt_pc;
    logic                  vld_p0;
    logic [1:0]            unused_redirect_lsb;

    function automatic logic [PC_WIDTH-1:0] seq_pc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(4);
    endfunction

    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction

    assign unused_redirect_lsb = redirect_pc_i[1:0];

    // Request selection: redirect beats boot, boot beats stall.
    always_comb begin
        nxt_pc = req_pc_p0;
        if (redirect_i) begin
            nxt_pc = word_align(redirect_pc_i);
        end else if (state == RUN && !stall_i) begin
            nxt_pc = seq_pc(req_pc_p0);
        end
    end

    assign rom_addr_o = nxt_pc[ADDR_WIDTH+1:2];

    // req_pc_p0 always names the word currently presented on rom_data_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= BOOT;
            req_pc_p0 <= RESET_PC;
        end else begin
            state     <= RUN;
            req_pc_p0 <= nxt_pc;
        end
    end

    assign vld_p0  = (state == RUN);
    assign instr_o = vld_p0 ? rom_data_i : NOP_INSTR;
    assign pc_o    = req_pc_p0;
    assign valid_o = vld_p0 & ~redirect_i;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (valid_o && !stall_i) fetch_cnt <= fetch_cnt + 32'd1;
            if (valid_o && stall_i)  stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt;
    assign stall_cnt_o = stall_cnt;
`else
    assign fetch_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
